dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory end of the CPU MEM-stage load/store port (dm_addr/dm_din/dm_dout/dm_rd_ctrl/dm_wr_ctrl).
//  Accepts one request at a time via req/ready, inserts WAIT_CYCLES wait states, then returns one response pulse with data or error.
//  Little-endian doubleword-organised RAM; load sign/zero extension happens here, so the MEM stage stores dm_dout as-is.
// PARAMETERS
//  DEPTH        512          number of 64-bit words; legal byte addresses are 0 .. DEPTH*8-1
//  WAIT_CYCLES  1            wait states between accept and response, 0..15
//  MMIO_ADDR    64'h1000_0000 tohost register address (used only with DMEM_MMIO_EN)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  dm_req         in   1   request valid; accepted when dm_req && dm_ready
//  dm_ready       out  1   high only in IDLE
//  dm_we          in   1   1=store, 0=load (sampled on accept)
//  dm_rd_ctrl     in   3   load type: 0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 LWU,7 LD
//  dm_wr_ctrl     in   2   store size: 0 SB,1 SH,2 SW,3 SD
//  dm_addr        in   64  byte address
//  dm_din         in   64  store data, right-aligned (low bytes used)
//  dm_resp_valid  out  1   one-cycle response pulse
//  dm_dout        out  64  load result, extended to 64 bits; 0 on stores and errors
//  dm_err         out  1   valid with dm_resp_valid: misaligned, out-of-range or illegal request
//  tohost_valid   out  1   (DMEM_MMIO_EN only) one-cycle pulse on tohost write
//  tohost_data    out  64  (DMEM_MMIO_EN only) last value written to MMIO_ADDR
// BEHAVIOUR
//  - Reset: state=IDLE, dm_ready=1, dm_resp_valid=0, dm_dout=0, dm_err=0, wait counter=0, tohost_valid=0, tohost_data=0.
//    RAM contents are not reset.
//  - FSM: IDLE -(accept)-> WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0); WAIT counts down to 1 -> RESP; RESP -> IDLE.
//  - Request latch: addr/din/we/ctrl are captured on accept. Later input changes have no effect until the next accept.
//  - Latency: response pulse arrives WAIT_CYCLES+1 cycles after the accept edge.
//    dm_ready is 0 from the accept edge until the response cycle; it is 1 again the cycle after dm_resp_valid.
//  - dm_resp_valid, dm_dout and dm_err are registered and held for exactly the RESP cycle.
//    In every other cycle they are 0, 0, 0.
//  - Alignment: size 1/2/4/8 requires addr[0]/addr[1:0]/addr[2:0] == 0.
//    Lane = addr[2:0]; word index = addr[63:3].
//  - Error cases; each gives dm_err=1, dm_dout=0 and no RAM write:
//    - misaligned address
//    - word index >= DEPTH
//    - load with dm_rd_ctrl==0
//    - store with dm_rd_ctrl!=0
//  - Loads: extract the bytes at the lane. LB/LH/LW sign-extend from bit 7/15/31. LBU/LHU/LWU zero-extend. LD returns the full word.
//  - Stores: write the low 1/2/4/8 bytes of dm_din into the addressed lanes via a byte mask; other bytes are unchanged.
//    The write commits on the WAIT->RESP (or IDLE->RESP) edge.
//  - Read-after-write: a load accepted after a store's response observes the stored data.
//  - Reset mid-operation (WAIT/RESP): return to IDLE, no response pulse. A store not yet committed is dropped; a committed store stays.
//  - dm_req while not ready is ignored, not queued; the requester holds it until dm_ready.
// CONFIGURATION
//  DMEM_MMIO_EN defined:
//   - an aligned SD to MMIO_ADDR does not touch RAM; on the commit edge it sets tohost_data=din and pulses tohost_valid for one cycle; no error.
//   - an LD from MMIO_ADDR returns tohost_data.
//   - any other access size to MMIO_ADDR gives dm_err.
//  DMEM_MMIO_EN undefined: tohost ports are absent and MMIO_ADDR is treated as an ordinary RAM address (normally out of range -> dm_err).
// TESTING
//  - Reset, then SD addr=0x10 din=0x8877665544332211, then LD 0x10 -> dm_dout=0x8877665544332211, err=0; response 2 cycles after each accept (WAIT_CYCLES=1).
//  - SB 0x13 din=0xFF over that word, then LB 0x13 -> 0xFFFFFFFFFFFFFFFF; LBU 0x13 -> 0xFF; LD 0x10 -> 0x88776655FF332211.
//  - LH 0x11 -> err=1, dout=0; SW 0x14 -> OK; SW 0x16 -> err=1 and LD 0x10 unchanged; LW/LWU 0x14 with 0x80000000 -> 0xFFFFFFFF80000000 / 0x0000000080000000.
//  - Address DEPTH*8 (0x1000) -> err=1; dm_req held high continuously -> accepts spaced WAIT_CYCLES+2 cycles apart, dm_ready never high during WAIT/RESP.
//  - rst asserted in WAIT of SD 0x20 din=5 -> no resp pulse, dm_ready=1 the next cycle, LD 0x20 returns the old value; with WAIT_CYCLES=0 the response comes 1 cycle after accept.
//  - DMEM_MMIO_EN: SD MMIO_ADDR din=1 -> tohost_valid pulses once with tohost_data=1, LD MMIO_ADDR -> 1; SW MMIO_ADDR -> err=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM-stage load/store port: one request at a time,
// WAIT_CYCLES wait states, one registered response pulse. Optional tohost MMIO via DMEM_MMIO_EN.
module dmem_responder #(
   parameter int unsigned DEPTH       = 512,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [63:0] MMIO_ADDR   = 64'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dm_req,
   output logic        dm_ready,
   input  logic        dm_we,
   input  logic [2:0]  dm_rd_ctrl,
   input  logic [1:0]  dm_wr_ctrl,
   input  logic [63:0] dm_addr,
   input  logic [63:0] dm_din,
   output logic        dm_resp_valid,
   output logic [63:0] dm_dout,
   output logic        dm_err
`ifdef DMEM_MMIO_EN
   ,
   output logic        tohost_valid,
   output logic [63:0] tohost_data
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

   state_t            state_r, state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic              go_resp_s, accept_s;
   logic              ready_r, resp_valid_r, err_r;
   logic [63:0]       dout_r;
   logic [63:0]       addr_r, din_r;
   logic              we_r;
   logic [2:0]        rd_ctrl_r;
   logic [1:0]        wr_ctrl_r;
   logic [63:0]       cur_addr_s, cur_din_s;
   logic              cur_we_s;
   logic [2:0]        cur_rd_ctrl_s;
   logic [1:0]        cur_wr_ctrl_s;
   logic [2:0]        lane_s;
   logic [IDX_W-1:0]  idx_s;
   logic [7:0]        size_mask_s, wmask_s;
   logic [63:0]       wdata_s, word_s, sh_s, load_s;
   logic              misalign_s, range_err_s, illegal_s, err_s, mmio_hit_s, commit_s;
   logic              tohost_valid_r;
   logic [63:0]       tohost_data_r;
   logic [63:0]       mem_r [DEPTH];

   assign accept_s = dm_req && (state_r == ST_IDLE);

   // Request view: live inputs while idle (needed when WAIT_CYCLES is 0), latched copy otherwise.
   always_comb begin
      if (state_r == ST_IDLE) begin
         cur_addr_s    = dm_addr;
         cur_din_s     = dm_din;
         cur_we_s      = dm_we;
         cur_rd_ctrl_s = dm_rd_ctrl;
         cur_wr_ctrl_s = dm_wr_ctrl;
      end else begin
         cur_addr_s    = addr_r;
         cur_din_s     = din_r;
         cur_we_s      = we_r;
         cur_rd_ctrl_s = rd_ctrl_r;
         cur_wr_ctrl_s = wr_ctrl_r;
      end
   end

   assign lane_s = cur_addr_s[2:0];
   assign idx_s  = cur_addr_s[IDX_W+2:3];

   // Access size, alignment and legality decode.
   always_comb begin
      size_mask_s = 8'h00;
      if (cur_we_s) begin
         case (cur_wr_ctrl_s)
            2'd0:    size_mask_s = 8'h01;
            2'd1:    size_mask_s = 8'h03;
            2'd2:    size_mask_s = 8'h0F;
            default: size_mask_s = 8'hFF;
         endcase
         illegal_s = (cur_rd_ctrl_s != 3'd0);
      end else begin
         case (cur_rd_ctrl_s)
            3'd1, 3'd2: size_mask_s = 8'h01;
            3'd3, 3'd4: size_mask_s = 8'h03;
            3'd5, 3'd6: size_mask_s = 8'h0F;
            3'd7:       size_mask_s = 8'hFF;
            default:    size_mask_s = 8'h00;
         endcase
         illegal_s = (cur_rd_ctrl_s == 3'd0);
      end
      case (size_mask_s)
         8'h03:   misalign_s = cur_addr_s[0];
         8'h0F:   misalign_s = (cur_addr_s[1:0] != 2'd0);
         8'hFF:   misalign_s = (cur_addr_s[2:0] != 3'd0);
         default: misalign_s = 1'b0;
      endcase
      range_err_s = (cur_addr_s[63:3] >= 61'(DEPTH));
`ifdef DMEM_MMIO_EN
      mmio_hit_s = (cur_addr_s == MMIO_ADDR);
      if (mmio_hit_s) begin
         err_s = cur_we_s ? !((cur_wr_ctrl_s == 2'd3) && (cur_rd_ctrl_s == 3'd0))
                          : (cur_rd_ctrl_s != 3'd7);
      end else begin
         err_s = misalign_s || range_err_s || illegal_s;
      end
`else
      mmio_hit_s = 1'b0;
      err_s      = misalign_s || range_err_s || illegal_s;
`endif
   end

`ifndef DMEM_MMIO_EN
   logic unused_mmio_s;
   assign unused_mmio_s = ^MMIO_ADDR;
`endif

   assign word_s  = mem_r[idx_s];
   assign sh_s    = word_s >> {lane_s, 3'b000};
   assign wdata_s = cur_din_s << {lane_s, 3'b000};
   assign wmask_s = size_mask_s << lane_s;

   // Load extraction with sign/zero extension.
   always_comb begin
      case (cur_rd_ctrl_s)
         3'd1:    load_s = {{56{sh_s[7]}}, sh_s[7:0]};
         3'd2:    load_s = {56'd0, sh_s[7:0]};
         3'd3:    load_s = {{48{sh_s[15]}}, sh_s[15:0]};
         3'd4:    load_s = {48'd0, sh_s[15:0]};
         3'd5:    load_s = {{32{sh_s[31]}}, sh_s[31:0]};
         3'd6:    load_s = {32'd0, sh_s[31:0]};
         3'd7:    load_s = sh_s;
         default: load_s = 64'd0;
      endcase
      if (mmio_hit_s) begin
         load_s = tohost_data_r;
      end else begin
         load_s = load_s;
      end
   end

   // Next-state logic; go_resp_s marks the commit/response edge.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      go_resp_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (WAIT_CYCLES == 0) begin
                  state_s   = ST_RESP;
                  go_resp_s = 1'b1;
               end else begin
                  state_s = ST_WAIT;
                  cnt_s   = 4'(WAIT_CYCLES);
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r <= 4'd1) begin
               state_s   = ST_RESP;
               go_resp_s = 1'b1;
               cnt_s     = 4'd0;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   assign commit_s = go_resp_s && cur_we_s && !err_s && !mmio_hit_s;

   // State, request latch and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         cnt_r          <= 4'd0;
         ready_r        <= 1'b1;
         resp_valid_r   <= 1'b0;
         dout_r         <= 64'd0;
         err_r          <= 1'b0;
         addr_r         <= 64'd0;
         din_r          <= 64'd0;
         we_r           <= 1'b0;
         rd_ctrl_r      <= 3'd0;
         wr_ctrl_r      <= 2'd0;
         tohost_valid_r <= 1'b0;
         tohost_data_r  <= 64'd0;
      end else begin
         state_r        <= state_s;
         cnt_r          <= cnt_s;
         ready_r        <= (state_s == ST_IDLE);
         resp_valid_r   <= go_resp_s;
         dout_r         <= (go_resp_s && !err_s && !cur_we_s) ? load_s : 64'd0;
         err_r          <= go_resp_s && err_s;
         tohost_valid_r <= go_resp_s && cur_we_s && mmio_hit_s && !err_s;
         if (go_resp_s && cur_we_s && mmio_hit_s && !err_s) begin
            tohost_data_r <= cur_din_s;
         end
         if (accept_s) begin
            addr_r    <= dm_addr;
            din_r     <= dm_din;
            we_r      <= dm_we;
            rd_ctrl_r <= dm_rd_ctrl;
            wr_ctrl_r <= dm_wr_ctrl;
         end
      end
   end

   // Byte-masked RAM write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && commit_s) begin
         for (int i = 0; i < 8; i++) begin
            if (wmask_s[i]) begin
               mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
         end
      end
   end

   assign dm_ready      = ready_r;
   assign dm_resp_valid = resp_valid_r;
   assign dm_dout       = dout_r;
   assign dm_err        = err_r;
`ifdef DMEM_MMIO_EN
   assign tohost_valid  = tohost_valid_r;
   assign tohost_data   = tohost_data_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_CYCLES=1 main instance, WAIT_CYCLES=0 latency instance).
module tb_dmem_responder;

   localparam logic [63:0] MMIO = 64'h1000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req = 1'b0, ready, we = 1'b0, resp_valid, err;
   logic [2:0] rd_ctrl = 3'd0;
   logic [1:0] wr_ctrl = 2'd0;
   logic [63:0] addr = 64'd0, din = 64'd0, dout;
   logic req0 = 1'b0, ready0, we0 = 1'b0, resp_valid0, err0;
   logic [2:0] rd_ctrl0 = 3'd0;
   logic [1:0] wr_ctrl0 = 2'd0;
   logic [63:0] addr0 = 64'd0, din0 = 64'd0, dout0;
`ifdef DMEM_MMIO_EN
   logic th_valid, th_valid0;
   logic [63:0] th_data, th_data0;
   int th_cnt = 0;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic busy = 1'b0;
   logic resp_prev = 1'b0;
   logic held_mode = 1'b0;
   logic [64:0] exp_q[$];
   int lat_q[$];
   int acc_log[$];

   dmem_responder #(.DEPTH(512), .WAIT_CYCLES(1), .MMIO_ADDR(MMIO)) u_dut (
      .clk(clk), .rst(rst), .dm_req(req), .dm_ready(ready), .dm_we(we),
      .dm_rd_ctrl(rd_ctrl), .dm_wr_ctrl(wr_ctrl), .dm_addr(addr), .dm_din(din),
      .dm_resp_valid(resp_valid), .dm_dout(dout), .dm_err(err)
`ifdef DMEM_MMIO_EN
      , .tohost_valid(th_valid), .tohost_data(th_data)
`endif
   );

   dmem_responder #(.DEPTH(512), .WAIT_CYCLES(0), .MMIO_ADDR(MMIO)) u_dut0 (
      .clk(clk), .rst(rst), .dm_req(req0), .dm_ready(ready0), .dm_we(we0),
      .dm_rd_ctrl(rd_ctrl0), .dm_wr_ctrl(wr_ctrl0), .dm_addr(addr0), .dm_din(din0),
      .dm_resp_valid(resp_valid0), .dm_dout(dout0), .dm_err(err0)
`ifdef DMEM_MMIO_EN
      , .tohost_valid(th_valid0), .tohost_data(th_data0)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Response monitor: pops the scoreboard, checks latency and idle-cycle outputs.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) check_eq("ready_while_busy", 64'(ready), 64'd0);
         if (resp_prev) check_eq("ready_after_resp", 64'(ready), 64'd1);
         if (resp_valid) begin
            if (exp_q.size() > 0) begin
               logic [64:0] e;
               e = exp_q.pop_front();
               check_eq("dout", dout, e[63:0]);
               check_eq("err", 64'(err), 64'(e[64]));
            end else begin
               check_eq("unexpected_resp", 64'd1, 64'd0);
            end
            if (lat_q.size() > 0) check_eq("latency", 64'(cyc - lat_q.pop_front()), 64'd2);
            else check_eq("latency_no_accept", 64'd1, 64'd0);
            busy = 1'b0;
         end else begin
            check_eq("idle_outputs_zero", dout | 64'(err), 64'd0);
         end
         resp_prev = resp_valid;
         if (req && ready) begin
            lat_q.push_back(cyc);
            if (held_mode) acc_log.push_back(cyc);
            busy = 1'b1;
         end
      end
   end

`ifdef DMEM_MMIO_EN
   always @(negedge clk) if (!rst && th_valid) th_cnt++;
`endif

   task automatic wait_accept();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!ok) check_eq("accept_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      if (!ok) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // One request on the WAIT_CYCLES=1 instance; inputs are scrambled after accept.
   task automatic do_req(input logic w, input logic [2:0] rc, input logic [1:0] wc,
                         input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] ed, input logic ee);
      exp_q.push_back({ee, ed});
      we = w; rd_ctrl = rc; wr_ctrl = wc; addr = a; din = d; req = 1'b1;
      wait_accept();
      req = 1'b0;
      we = ~w;
      rd_ctrl = 3'($urandom);
      wr_ctrl = 2'($urandom);
      addr = {$urandom, $urandom};
      din = {$urandom, $urandom};
      drain();
   endtask

   // One request on the WAIT_CYCLES=0 instance; response expected in the next cycle.
   task automatic do_req0(input logic w, input logic [2:0] rc, input logic [1:0] wc,
                          input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] ed, input logic ee);
      we0 = w; rd_ctrl0 = rc; wr_ctrl0 = wc; addr0 = a; din0 = d; req0 = 1'b1;
      @(negedge clk);
      check_eq("w0_ready", 64'(ready0), 64'd1);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      @(negedge clk);
      check_eq("w0_resp_valid", 64'(resp_valid0), 64'd1);
      check_eq("w0_dout", dout0, ed);
      check_eq("w0_err", 64'(err0), 64'(ee));
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", 64'(ready), 64'd1);
      check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("rst_dout", dout, 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_ready0", 64'(ready0), 64'd1);
      @(posedge clk);
      #1;

      // rd: 1 LB 2 LBU 3 LH 4 LHU 5 LW 6 LWU 7 LD; wr: 0 SB 1 SH 2 SW 3 SD
      do_req(1'b1, 3'd0, 2'd3, 64'h10, 64'h8877665544332211, 64'd0, 1'b0);
      do_req(1'b0, 3'd7, 2'd0, 64'h10, 64'd0, 64'h8877665544332211, 1'b0);
      do_req(1'b1, 3'd0, 2'd0, 64'h13, 64'hFF, 64'd0, 1'b0);
      do_req(1'b0, 3'd1, 2'd0, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      do_req(1'b0, 3'd2, 2'd0, 64'h13, 64'd0, 64'h00000000000000FF, 1'b0);
      do_req(1'b0, 3'd7, 2'd0, 64'h10, 64'd0, 64'h88776655FF332211, 1'b0);
      do_req(1'b0, 3'd3, 2'd0, 64'h11, 64'd0, 64'd0, 1'b1);
      do_req(1'b1, 3'd0, 2'd2, 64'h14, 64'h80000000, 64'd0, 1'b0);
      do_req(1'b1, 3'd0, 2'd2, 64'h16, 64'h12345678, 64'd0, 1'b1);
      do_req(1'b0, 3'd7, 2'd0, 64'h10, 64'd0, 64'h80000000FF332211, 1'b0);
      do_req(1'b0, 3'd5, 2'd0, 64'h14, 64'd0, 64'hFFFFFFFF80000000, 1'b0);
      do_req(1'b0, 3'd6, 2'd0, 64'h14, 64'd0, 64'h0000000080000000, 1'b0);
      do_req(1'b0, 3'd3, 2'd0, 64'h12, 64'd0, 64'hFFFFFFFFFFFFFF33, 1'b0);
      do_req(1'b0, 3'd4, 2'd0, 64'h12, 64'd0, 64'h000000000000FF33, 1'b0);
      do_req(1'b0, 3'd7, 2'd0, 64'h1000, 64'd0, 64'd0, 1'b1);
      do_req(1'b1, 3'd0, 2'd0, 64'h1000, 64'h55, 64'd0, 1'b1);
      do_req(1'b0, 3'd0, 2'd0, 64'h10, 64'd0, 64'd0, 1'b1);
      do_req(1'b1, 3'd7, 2'd3, 64'h10, 64'd0, 64'd0, 1'b1);
      do_req(1'b1, 3'd0, 2'd1, 64'h1E, 64'hFFFF_ABCD, 64'd0, 1'b0);
      do_req(1'b0, 3'd4, 2'd0, 64'h1E, 64'd0, 64'h000000000000ABCD, 1'b0);
      do_req(1'b0, 3'd7, 2'd0, 64'h10, 64'd0, 64'h80000000FF332211, 1'b0);

      // dm_req held high: three back-to-back LDs accepted WAIT_CYCLES+2 apart
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 64'h80000000FF332211});
      held_mode = 1'b1;
      we = 1'b0; rd_ctrl = 3'd7; wr_ctrl = 2'd0; addr = 64'h10; din = 64'd0; req = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         if (acc_log.size() >= 3) break;
      end
      #1;
      req = 1'b0;
      held_mode = 1'b0;
      drain();
      check_eq("held_accepts", 64'(acc_log.size()), 64'd3);
      if (acc_log.size() == 3) begin
         check_eq("held_spacing_1", 64'(acc_log[1] - acc_log[0]), 64'd3);
         check_eq("held_spacing_2", 64'(acc_log[2] - acc_log[1]), 64'd3);
      end

      // reset during WAIT of a store drops it
      do_req(1'b1, 3'd0, 2'd3, 64'h20, 64'hAAAA, 64'd0, 1'b0);
      we = 1'b1; rd_ctrl = 3'd0; wr_ctrl = 2'd3; addr = 64'h20; din = 64'd5; req = 1'b1;
      wait_accept();
      req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      lat_q.delete();
      busy = 1'b0;
      @(negedge clk);
      check_eq("midrst_ready", 64'(ready), 64'd1);
      check_eq("midrst_no_resp", 64'(resp_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      do_req(1'b0, 3'd7, 2'd0, 64'h20, 64'd0, 64'hAAAA, 1'b0);

      // zero wait states
      do_req0(1'b1, 3'd0, 2'd3, 64'h8, 64'h1234, 64'd0, 1'b0);
      do_req0(1'b0, 3'd7, 2'd0, 64'h8, 64'd0, 64'h1234, 1'b0);
      do_req0(1'b0, 3'd1, 2'd0, 64'h9, 64'd0, 64'h12, 1'b0);
      do_req0(1'b0, 3'd5, 2'd0, 64'hA, 64'd0, 64'd0, 1'b1);

`ifdef DMEM_MMIO_EN
      do_req(1'b1, 3'd0, 2'd3, MMIO, 64'd1, 64'd0, 1'b0);
      check_eq("tohost_pulses", 64'(th_cnt), 64'd1);
      check_eq("tohost_data", th_data, 64'd1);
      do_req(1'b0, 3'd7, 2'd0, MMIO, 64'd0, 64'd1, 1'b0);
      do_req(1'b1, 3'd0, 2'd2, MMIO, 64'd7, 64'd0, 1'b1);
      check_eq("tohost_pulses_after_sw", 64'(th_cnt), 64'd1);
`else
      do_req(1'b0, 3'd7, 2'd0, MMIO, 64'd0, 64'd0, 1'b1);
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
